// File: rtl/uart_pkg.sv
// Shared UART definitions: bit period helper, data width and frame states.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic int bit_period(int freq, int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: byte, valid/ack and status pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rdata;
    logic                 rvalid;
    logic                 rdreq;
    logic                 busy;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rdata,
        output rvalid,
        input  rdreq,
        output busy,
        output frame_err,
        output overrun
    );

    modport slave (
        input  rdata,
        input  rvalid,
        output rdreq,
        input  busy,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin; resets to line idle (1).
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 frames.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUDRATE = 115200,
    parameter int FREQ     = 50_000_000
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int T    = bit_period(FREQ, BAUDRATE);
    localparam int HALF = T / 2;
    localparam int CW   = $clog2(T);
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] T_LAST = CW'(T - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HALF - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic                 armed_q, armed_d;
    logic                 par_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
`endif

    uart_rx_sync #(
        .STAGES(2)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    assign par_bad = par_q != ^sh_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
            armed_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
            armed_q  <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q & ~bus.rdreq;
        fe_d     = 1'b0;
        ov_d     = 1'b0;
        // a held-low line (break) must go high before a new start is accepted
        armed_d  = armed_q | rx_s;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (armed_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == H_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == T_LAST) begin
                    cnt_d       = '0;
                    sh_d[bit_q] = rx_s;
                    bit_d       = bit_q + 1'b1;
                    if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == T_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == T_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_s) begin
                        fe_d    = 1'b1;
                        armed_d = 1'b0;
                    end else if (par_bad) begin
                        fe_d = 1'b1;
                    end else begin
                        rdata_d  = sh_q;
                        rvalid_d = 1'b1;
                        ov_d     = rvalid_q & ~bus.rdreq;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default BAUDRATE/FREQ (T=434).
module tb_uart_rx;

    localparam int T = 434;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 3 + T / 2 + 10 * T;
`else
    localparam int LAT = 3 + T / 2 + 9 * T;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int rise_cyc  = -1;
    int fe_hi     = 0;
    int ov_hi     = 0;
    logic rv_prev = 1'b0;

    uart_rx_if bus ();

    uart_rx #(
        .BAUDRATE(115200),
        .FREQ    (50_000_000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_err) fe_hi++;
        if (bus.overrun) ov_hi++;
        if (bus.rvalid && !rv_prev) rise_cyc = cyc;
        rv_prev = bus.rvalid;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_time(logic b);
        rx = b;
        repeat (T) @(posedge clk);
        #1;
    endtask

    task automatic wait_clks(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] d, logic stop);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        rise_cyc  = -1;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(^d);
`endif
        bit_time(stop);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par(logic [7:0] d, logic par);
        @(posedge clk);
        #1;
        rise_cyc = -1;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time(par);
        bit_time(1'b1);
    endtask
`endif

    task automatic ack();
        @(negedge clk);
        bus.rdreq = 1'b1;
        @(posedge clk);
        #1;
        bus.rdreq = 1'b0;
    endtask

    initial begin
        bus.rdreq = 1'b0;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(2);
        check("rst_rdata", 32'(bus.rdata), 32'h00);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_fe", 32'(fe_hi), 32'd0);
        check("rst_ov", 32'(ov_hi), 32'd0);

        send(8'h41, 1'b1);
        wait_clks(2);
        check("a41_lat", 32'(rise_cyc - start_cyc), 32'(LAT));
        check("a41_rvalid", 32'(bus.rvalid), 32'h1);
        check("a41_rdata", 32'(bus.rdata), 32'h41);
        check("a41_fe", 32'(fe_hi), 32'd0);
        check("a41_busy", 32'(bus.busy), 32'h0);
        ack();
        check("a41_ack", 32'(bus.rvalid), 32'h0);

        @(posedge clk);
        #1;
        rx = 1'b0;
        wait_clks(50);
        check("glitch_busy_mid", 32'(bus.busy), 32'h1);
        wait_clks(50);
        rx = 1'b1;
        wait_clks(300);
        check("glitch_busy", 32'(bus.busy), 32'h0);
        check("glitch_rvalid", 32'(bus.rvalid), 32'h0);
        check("glitch_fe", 32'(fe_hi), 32'd0);

        send(8'h55, 1'b0);
        wait_clks(5);
        check("fe55_pulse", 32'(fe_hi), 32'd1);
        check("fe55_rvalid", 32'(bus.rvalid), 32'h0);
        check("fe55_rdata", 32'(bus.rdata), 32'h41);
        check("fe55_ov", 32'(ov_hi), 32'd0);
        check("fe55_busy", 32'(bus.busy), 32'h0);

        send(8'hA5, 1'b1);
        check("ovr_first", 32'(bus.rdata), 32'hA5);
        send(8'h3C, 1'b1);
        wait_clks(5);
        check("ovr_pulse", 32'(ov_hi), 32'd1);
        check("ovr_rdata", 32'(bus.rdata), 32'h3C);
        check("ovr_rvalid", 32'(bus.rvalid), 32'h1);
        check("ovr_fe", 32'(fe_hi), 32'd1);
        ack();
        check("ovr_ack", 32'(bus.rvalid), 32'h0);

        @(posedge clk);
        #1;
        rise_cyc = -1;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        wait_clks(T / 2);
        check("rst_mid_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        check("rst_mid_idle", 32'(bus.busy), 32'h0);
        wait_clks(5 * T);
        check("rst_mid_busy2", 32'(bus.busy), 32'h0);
        check("rst_mid_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_mid_rise", 32'(rise_cyc), 32'hFFFF_FFFF);
        check("rst_mid_rdata", 32'(bus.rdata), 32'h00);

        send(8'h12, 1'b1);
        wait_clks(2);
        check("a12_rdata", 32'(bus.rdata), 32'h12);
        check("a12_rvalid", 32'(bus.rvalid), 32'h1);
        check("a12_lat", 32'(rise_cyc - start_cyc), 32'(LAT));
        check("a12_fe", 32'(fe_hi), 32'd1);
        ack();

`ifdef UART_RX_PARITY_EN
        send_par(8'h03, 1'b1);
        wait_clks(5);
        check("par_bad_fe", 32'(fe_hi), 32'd2);
        check("par_bad_rvalid", 32'(bus.rvalid), 32'h0);
        check("par_bad_rdata", 32'(bus.rdata), 32'h12);
        send_par(8'h03, 1'b0);
        wait_clks(5);
        check("par_ok_rdata", 32'(bus.rdata), 32'h03);
        check("par_ok_rvalid", 32'(bus.rvalid), 32'h1);
        check("par_ok_fe", 32'(fe_hi), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
